// File: rtl/ahb_lite_interconnect.sv
// Single-master AHB-Lite interconnect: parameterised address decode, data-phase
// response mux, and a built-in default slave that answers unmapped transfers with ERROR.
module ahb_lite_interconnect #(
    parameter int                                DATA_WIDTH    = 32,
    parameter int                                ADDR_WIDTH    = 32,
    parameter int                                NUM_SLAVES    = 2,
    parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0]  SLAVE_BASE    = {32'h4000_0000, 32'h0000_0000},
    parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0]  SLAVE_MASK    = {32'hFFFF_FF00, 32'hFFFF_0000},
    parameter int                                ERR_CNT_WIDTH = 16
) (
    input  logic                             HCLK,
    input  logic                             HRESET,
    input  logic [ADDR_WIDTH-1:0]            HADDR,
    input  logic [1:0]                       HTRANS,
    output logic [NUM_SLAVES-1:0]            HSEL,
    input  logic [NUM_SLAVES-1:0]            HREADYOUT_S,
    input  logic [NUM_SLAVES-1:0]            HRESP_S,
    input  logic [NUM_SLAVES*DATA_WIDTH-1:0] HRDATA_S,
    output logic                             HREADY,
    output logic                             HRESP,
    output logic [DATA_WIDTH-1:0]            HRDATA,
    output logic [ERR_CNT_WIDTH-1:0]         ERR_CNT
);

    localparam int            SW      = $clog2(NUM_SLAVES + 1);
    localparam logic [SW-1:0] DEF_IDX = SW'(NUM_SLAVES);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ERR1 = 2'd1,
        ST_ERR2 = 2'd2
    } ds_state_e;

    ds_state_e                ds_q;
    logic [SW-1:0]            dsel_q;
    logic [SW-1:0]            dsel_d;
    logic [ERR_CNT_WIDTH-1:0] err_cnt_q;
    logic [ERR_CNT_WIDTH-1:0] err_cnt_d;
    logic [SW-1:0]            dec_idx_s;
    logic [NUM_SLAVES-1:0]    hsel_s;
    logic                     hit_s;
    logic                     hready_s;
    logic                     hresp_s;
    logic [DATA_WIDTH-1:0]    hrdata_s;
    logic                     err_start_s;
    logic                     unused_htrans_s;

    assign unused_htrans_s = HTRANS[0];

    // Address decode; scanning downwards lets the lowest matching index win.
    always_comb begin
        dec_idx_s = DEF_IDX;
        hsel_s    = '0;
        hit_s     = 1'b0;
        for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
            if ((HADDR & SLAVE_MASK[i*ADDR_WIDTH +: ADDR_WIDTH]) ==
                SLAVE_BASE[i*ADDR_WIDTH +: ADDR_WIDTH]) begin
                dec_idx_s = SW'(i);
                hsel_s    = '0;
                hsel_s[i] = 1'b1;
                hit_s     = 1'b1;
            end else begin
                hit_s     = hit_s;
            end
        end
    end

    // Response mux: default-slave values unless the data phase belongs to a real slave.
    always_comb begin
        hready_s = (ds_q != ST_ERR1);
        hresp_s  = (ds_q != ST_IDLE);
        hrdata_s = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (dsel_q == SW'(i)) begin
                hready_s = HREADYOUT_S[i];
                hresp_s  = HRESP_S[i];
                hrdata_s = HRDATA_S[i*DATA_WIDTH +: DATA_WIDTH];
            end else begin
                hrdata_s = hrdata_s;
            end
        end
    end

    assign err_start_s = hready_s & ~hit_s & HTRANS[1];

    // Next data-phase owner and saturating error count.
    always_comb begin
        if (hready_s) begin
            dsel_d = dec_idx_s;
        end else begin
            dsel_d = dsel_q;
        end
        if (err_start_s && (err_cnt_q != {ERR_CNT_WIDTH{1'b1}})) begin
            err_cnt_d = err_cnt_q + ERR_CNT_WIDTH'(1);
        end else begin
            err_cnt_d = err_cnt_q;
        end
    end

    // Default-slave FSM plus data-phase owner and error counter registers.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            ds_q      <= ST_IDLE;
            dsel_q    <= DEF_IDX;
            err_cnt_q <= '0;
        end else begin
            dsel_q    <= dsel_d;
            err_cnt_q <= err_cnt_d;
            case (ds_q)
                ST_IDLE: ds_q <= err_start_s ? ST_ERR1 : ST_IDLE;
                ST_ERR1: ds_q <= ST_ERR2;
                ST_ERR2: ds_q <= err_start_s ? ST_ERR1 : ST_IDLE;
                default: ds_q <= ST_IDLE;
            endcase
        end
    end

    assign HSEL    = hsel_s;
    assign HREADY  = hready_s;
    assign HRESP   = hresp_s;
    assign HRDATA  = hrdata_s;
    assign ERR_CNT = err_cnt_q;

endmodule

// File: tb/tb_ahb_lite_interconnect.sv
// Directed bench for ahb_lite_interconnect: per-cycle checks of select/ready/response/count
// and a scoreboard of expected data-phase results pushed at address phase.
module tb_ahb_lite_interconnect;

    logic        HCLK;
    logic        HRESET;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic [1:0]  HSEL;
    logic [1:0]  HREADYOUT_S;
    logic [1:0]  HRESP_S;
    logic [63:0] HRDATA_S;
    logic        HREADY;
    logic        HRESP;
    logic [31:0] HRDATA;
    logic [15:0] ERR_CNT;

    typedef struct packed {
        logic        resp;
        logic [31:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    localparam logic [1:0] T_IDLE   = 2'd0;
    localparam logic [1:0] T_BUSY   = 2'd1;
    localparam logic [1:0] T_NONSEQ = 2'd2;
    localparam logic [1:0] T_SEQ    = 2'd3;

    ahb_lite_interconnect dut (
        .HCLK        (HCLK),
        .HRESET      (HRESET),
        .HADDR       (HADDR),
        .HTRANS      (HTRANS),
        .HSEL        (HSEL),
        .HREADYOUT_S (HREADYOUT_S),
        .HRESP_S     (HRESP_S),
        .HRDATA_S    (HRDATA_S),
        .HREADY      (HREADY),
        .HRESP       (HRESP),
        .HRDATA      (HRDATA),
        .ERR_CNT     (ERR_CNT)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic resp, input logic [31:0] data);
        exp_t e;
        e.resp = resp;
        e.data = data;
        exp_q.push_back(e);
    endtask

    // One bus cycle: drive inputs, check at the falling edge, advance past the rising edge.
    task automatic cyc(input string tag, input logic [31:0] addr, input logic [1:0] trans,
                       input logic [1:0] rdy, input logic [1:0] rsp,
                       input logic [31:0] rd0, input logic [31:0] rd1,
                       input logic [1:0] e_hsel, input logic e_rdy, input logic e_rsp,
                       input logic [15:0] e_cnt, input bit pop);
        exp_t e;
        HADDR       = addr;
        HTRANS      = trans;
        HREADYOUT_S = rdy;
        HRESP_S     = rsp;
        HRDATA_S    = {rd1, rd0};
        @(negedge HCLK);
        check({tag, ".hsel"},   {30'd0, HSEL},   {30'd0, e_hsel});
        check({tag, ".hready"}, {31'd0, HREADY}, {31'd0, e_rdy});
        check({tag, ".hresp"},  {31'd0, HRESP},  {31'd0, e_rsp});
        check({tag, ".errcnt"}, {16'd0, ERR_CNT}, {16'd0, e_cnt});
        if (pop) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL %s.sb: observed empty scoreboard expected an entry", tag);
            end else begin
                e = exp_q.pop_front();
                check({tag, ".sb_resp"}, {31'd0, HRESP}, {31'd0, e.resp});
                check({tag, ".sb_data"}, HRDATA, e.data);
            end
        end
        @(posedge HCLK);
        #1;
    endtask

    task automatic do_reset();
        HRESET      = 1'b1;
        HADDR       = 32'hFFFF_0000;
        HTRANS      = T_IDLE;
        HREADYOUT_S = 2'b11;
        HRESP_S     = 2'b00;
        HRDATA_S    = 64'd0;
        repeat (2) @(posedge HCLK);
        #1;
        HRESET = 1'b0;
        exp_q.delete();
        push(1'b0, 32'h0000_0000);
        cyc("reset", 32'hFFFF_0000, T_IDLE, 2'b11, 2'b00, 32'h1111_1111, 32'h2222_2222,
            2'b00, 1'b1, 1'b0, 16'd0, 1'b1);
    endtask

    initial begin
        do_reset();

        // mapped read to slave 0
        cyc("rd0_a", 32'h0000_0010, T_NONSEQ, 2'b11, 2'b00, 32'h0, 32'h0,
            2'b01, 1'b1, 1'b0, 16'd0, 1'b0);
        push(1'b0, 32'hCAFE_F00D);
        cyc("rd0_d", 32'hFFFF_0000, T_IDLE, 2'b11, 2'b00, 32'hCAFE_F00D, 32'h0,
            2'b00, 1'b1, 1'b0, 16'd0, 1'b1);

        // slave 1 with three wait states; new address to slave 0 must wait
        cyc("ws_a", 32'h4000_0004, T_NONSEQ, 2'b11, 2'b00, 32'h0, 32'h0,
            2'b10, 1'b1, 1'b0, 16'd0, 1'b0);
        push(1'b0, 32'h1234_5678);
        for (int k = 0; k < 3; k++) begin
            cyc("ws_wait", 32'h0000_0000, T_NONSEQ, 2'b01, 2'b00, 32'hDEAD_BEEF, 32'h0,
                2'b01, 1'b0, 1'b0, 16'd0, 1'b0);
        end
        cyc("ws_d", 32'h0000_0000, T_NONSEQ, 2'b11, 2'b01, 32'hDEAD_BEEF, 32'h1234_5678,
            2'b01, 1'b1, 1'b0, 16'd0, 1'b1);
        push(1'b0, 32'hA5A5_0000);

        // mapped data phase overlapped with an unmapped active address
        cyc("m2u_d", 32'h8000_0000, T_NONSEQ, 2'b11, 2'b00, 32'hA5A5_0000, 32'h0,
            2'b00, 1'b1, 1'b0, 16'd0, 1'b1);
        push(1'b1, 32'h0000_0000);
        cyc("err1", 32'h8000_0000, T_NONSEQ, 2'b11, 2'b00, 32'h0, 32'h0,
            2'b00, 1'b0, 1'b1, 16'd1, 1'b0);
        cyc("err2", 32'h8000_0000, T_IDLE, 2'b11, 2'b00, 32'h0, 32'h0,
            2'b00, 1'b1, 1'b1, 16'd1, 1'b1);
        push(1'b0, 32'h0000_0000);

        // unmapped IDLE and BUSY are zero-wait OKAY
        cyc("uidle", 32'h8000_0000, T_BUSY, 2'b11, 2'b00, 32'h0, 32'h0,
            2'b00, 1'b1, 1'b0, 16'd1, 1'b1);
        push(1'b0, 32'h0000_0000);
        cyc("ubusy", 32'h8000_0000, T_IDLE, 2'b11, 2'b00, 32'h0, 32'h0,
            2'b00, 1'b1, 1'b0, 16'd1, 1'b1);

        // back-to-back errors then a mapped transfer, starting from a fresh reset
        do_reset();
        cyc("b2b_a1", 32'h8000_0000, T_NONSEQ, 2'b11, 2'b00, 32'h0, 32'h0,
            2'b00, 1'b1, 1'b0, 16'd0, 1'b0);
        push(1'b1, 32'h0000_0000);
        cyc("b2b_e1a", 32'h8000_0100, T_SEQ, 2'b11, 2'b00, 32'h0, 32'h0,
            2'b00, 1'b0, 1'b1, 16'd1, 1'b0);
        cyc("b2b_e1b", 32'h8000_0100, T_SEQ, 2'b11, 2'b00, 32'h0, 32'h0,
            2'b00, 1'b1, 1'b1, 16'd1, 1'b1);
        push(1'b1, 32'h0000_0000);
        cyc("b2b_e2a", 32'h0000_0020, T_NONSEQ, 2'b11, 2'b00, 32'h0, 32'h0,
            2'b01, 1'b0, 1'b1, 16'd2, 1'b0);
        cyc("b2b_e2b", 32'h0000_0020, T_NONSEQ, 2'b11, 2'b00, 32'h0, 32'h0,
            2'b01, 1'b1, 1'b1, 16'd2, 1'b1);
        push(1'b0, 32'h1357_9BDF);
        cyc("b2b_m", 32'h8000_0000, T_NONSEQ, 2'b11, 2'b00, 32'h1357_9BDF, 32'h0,
            2'b00, 1'b1, 1'b0, 16'd2, 1'b1);

        // reset asserted while in the first error cycle
        HRESET = 1'b1;
        cyc("rst_err1", 32'h8000_0000, T_NONSEQ, 2'b11, 2'b00, 32'h0, 32'h0,
            2'b00, 1'b0, 1'b1, 16'd3, 1'b0);
        HRESET = 1'b0;
        exp_q.delete();
        push(1'b0, 32'h0000_0000);
        cyc("post_rst", 32'h8000_0000, T_IDLE, 2'b11, 2'b00, 32'h0, 32'h0,
            2'b00, 1'b1, 1'b0, 16'd0, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ahb_lite_interconnect.md
Name: ahb_lite_interconnect

Overview:
- Parametrised single-master AHB-Lite interconnect.
- Replaces the fixed two-slave decoder/multiplexor pair between the RISC-V wrapper and the memory, AES128 and future slaves.
- Decodes the address phase into NUM_SLAVES select lines using a parameter address map.
- Registers the data-phase owner and multiplexes slave responses back to the master.
- Contains a built-in default slave that returns the two-cycle AHB ERROR response for unmapped active transfers, and counts those errors.

Parameters:
- DATA_WIDTH, 32, width of HRDATA buses.
- ADDR_WIDTH, 32, width of HADDR.
- NUM_SLAVES, 2, number of slave ports (1..16).
- SLAVE_BASE, {32'h4000_0000, 32'h0000_0000}, packed NUM_SLAVES*ADDR_WIDTH base addresses; slave i occupies slice i.
- SLAVE_MASK, {32'hFFFF_FF00, 32'hFFFF_0000}, packed NUM_SLAVES*ADDR_WIDTH decode masks.
- ERR_CNT_WIDTH, 16, width of the unmapped-error counter.

Ports:
- HCLK  in  1  system clock; all state updates on rising edge.
- HRESET  in  1  synchronous reset, active-high.
- HADDR  in  ADDR_WIDTH  master address.
- HTRANS  in  2  master transfer type.
- HSEL  out  NUM_SLAVES  per-slave select, address phase.
- HREADYOUT_S  in  NUM_SLAVES  per-slave ready; bit i from slave i.
- HRESP_S  in  NUM_SLAVES  per-slave response.
- HRDATA_S  in  NUM_SLAVES*DATA_WIDTH  packed per-slave read data.
- HREADY  out  1  muxed ready to master and all slaves.
- HRESP  out  1  muxed response to master.
- HRDATA  out  DATA_WIDTH  muxed read data to master.
- ERR_CNT  out  ERR_CNT_WIDTH  count of unmapped active transfers.

Behaviour:
- Decode (combinational):
  - match[i] = ((HADDR & SLAVE_MASK[i]) == SLAVE_BASE[i]).
  - On overlap, the lowest index wins; HSEL is one-hot or all-zero.
  - HSEL is driven regardless of HTRANS; slaves qualify it with HTRANS and HREADY.
  - No match selects the internal default slave (index NUM_SLAVES).
- Data-phase owner register dsel:
  - Encoded index 0..NUM_SLAVES.
  - Loads the decoded index when HREADY=1; holds otherwise.
  - Reset value NUM_SLAVES (default slave, idle).
- Response mux (combinational from dsel):
  - dsel<NUM_SLAVES: HREADY=HREADYOUT_S[dsel], HRESP=HRESP_S[dsel], HRDATA=HRDATA_S slice dsel.
  - dsel=NUM_SLAVES: outputs come from the default slave.
- Default slave FSM, states IDLE, ERR1, ERR2:
  - IDLE: HREADY=1, HRESP=0. Goes to ERR1 when HREADY=1 and no match and HTRANS[1]=1 (NONSEQ/SEQ). IDLE/BUSY to unmapped space is a zero-wait OKAY.
  - ERR1: HREADY=0, HRESP=1; always goes to ERR2.
  - ERR2: HREADY=1, HRESP=1. Goes to ERR1 if another unmapped active transfer is sampled this cycle, else IDLE.
  - Default-slave HRDATA is always 0.
- Latency: 0 wait states for mapped slaves beyond what the slave inserts; exactly 2 cycles (1 wait) for unmapped errors.
- ERR_CNT:
  - Increments on each IDLE/ERR2 to ERR1 transition.
  - Saturates at all-ones; no wrap.
- Back-to-back transfers:
  - An address phase overlapping a slave's wait states is not sampled until HREADY=1; HSEL still follows HADDR.
  - mapped then unmapped, and unmapped then mapped, sequences must both work without bubbles.
- Reset: on HRESET=1 at a clock edge, dsel=NUM_SLAVES and the FSM goes to IDLE, regardless of an in-flight transfer. Outputs are then HREADY=1, HRESP=0, HRDATA=0, ERR_CNT=0.

Test Plan:
- Reset then idle: HRESET high 2 cycles -> HREADY=1, HRESP=0, HRDATA=0, ERR_CNT=0, HSEL=2'b00 for HADDR=32'hFFFF_0000.
- Mapped read: HADDR=32'h0000_0010, NONSEQ -> HSEL=2'b01; next cycle slave0 drives HRDATA_S=32'hCAFE_F00D with ready=1 -> HRDATA=32'hCAFE_F00D, HRESP=0.
- Wait states: HADDR=32'h4000_0004 NONSEQ; slave1 holds HREADYOUT_S[1]=0 for 3 cycles -> HREADY=0 for 3 cycles. A new HADDR=32'h0000_0000 presented meanwhile does not change dsel until HREADY=1.
- Unmapped active: HADDR=32'h8000_0000 NONSEQ -> next cycle HREADY=0/HRESP=1, following cycle HREADY=1/HRESP=1; ERR_CNT=1.
- Unmapped IDLE: HADDR=32'h8000_0000 HTRANS=IDLE -> HREADY=1, HRESP=0, ERR_CNT unchanged.
- Back-to-back: unmapped NONSEQ, then unmapped SEQ sampled in ERR2, then a mapped slave0 transfer -> two full error pairs, ERR_CNT=2, then slave0 data returned. Asserting HRESET during ERR1 -> next cycle HREADY=1, HRESP=0, ERR_CNT=0.
